mem_word_arb: RTL and testbench

- Two-requester controller for the shared byte-wide memory (8-bit write port, 32-bit aligned-word read with write-forwarding).
- Arbitrates between requesters A and B.
- Converts each 32-bit word write with byte enables into a sequence of single-byte writes.
- Issues word reads and returns read data with a one-cycle ack pulse per transaction.

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/mem_word_arb_if.sv | 46 ++++
 rtl/mem_arb_rr2.sv | 31 +++
 rtl/mem_word_arb.sv | 120 ++++++++++++
 tb/tb_mem_word_arb.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and lane helpers for the word-to-byte memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_RSP  = 2'd3
  } state_t;

  localparam int LANES = 4;

  localparam logic [1:0] LANE0 = 2'd0;
  localparam logic [1:0] LANE1 = 2'd1;
  localparam logic [1:0] LANE2 = 2'd2;
  localparam logic [1:0] LANE3 = 2'd3;

  // Lanes are written in ascending order, so the next lane is the lowest remaining enable.
  function automatic logic [1:0] lowest_lane(input logic [LANES-1:0] mask);
    if (mask[0])      return LANE0;
    else if (mask[1]) return LANE1;
    else if (mask[2]) return LANE2;
    else if (mask[3]) return LANE3;
    else              return LANE0;
  endfunction

endpackage

// File: rtl/mem_word_arb_if.sv
// rtl/mem_word_arb_if.sv - requester A/B word ports and byte-memory port of mem_word_arb
interface mem_word_arb_if #(
  parameter int ADDR_W = 8
) ();
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-3:0] a_waddr;
  logic [31:0]       a_wdata;
  logic [3:0]        a_be;
  logic              a_ack;
  logic [31:0]       a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-3:0] b_waddr;
  logic [31:0]       b_wdata;
  logic [3:0]        b_be;
  logic              b_ack;
  logic [31:0]       b_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wd;
  logic              mem_we;
  logic              mem_re;
  logic [31:0]       mem_rd;

  // Controller view
  modport slave (
    input  a_req, a_we, a_waddr, a_wdata, a_be,
    output a_ack, a_rdata,
    input  b_req, b_we, b_waddr, b_wdata, b_be,
    output b_ack, b_rdata,
    output mem_addr, mem_wd, mem_we, mem_re,
    input  mem_rd
  );

  // Requester and memory view
  modport master (
    output a_req, a_we, a_waddr, a_wdata, a_be,
    input  a_ack, a_rdata,
    output b_req, b_we, b_waddr, b_wdata, b_be,
    input  b_ack, b_rdata,
    input  mem_addr, mem_wd, mem_we, mem_re,
    output mem_rd
  );
endinterface

// File: rtl/mem_arb_rr2.sv
// rtl/mem_arb_rr2.sv - two-way arbiter, round-robin or fixed priority (bit 0 = A wins)
module mem_arb_rr2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_rr,
  input  logic       i_adv,
  output logic [1:0] o_gnt
);

  logic r_last_b;

  always_comb begin
    o_gnt = 2'b00;
    if (i_req == 2'b11) begin
      o_gnt = (i_rr && !r_last_b) ? 2'b10 : 2'b01;
    end else begin
      o_gnt = i_req;
    end
  end

  // Pointer starts at B so that A wins the first tie after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_b <= 1'b1;
    end else if (i_adv && (|o_gnt)) begin
      r_last_b <= o_gnt[1];
    end
  end

endmodule

// File: rtl/mem_word_arb.sv
// rtl/mem_word_arb.sv - arbitrates two word requesters onto a byte-write / word-read memory
module mem_word_arb
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int RR     = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_word_arb_if.slave  bus
);

  state_t            r_state;
  state_t            w_next;
  logic              r_gnt_b;
  logic              r_we;
  logic [ADDR_W-3:0] r_waddr;
  logic [31:0]       r_wdata;
  logic [LANES-1:0]  r_be;

  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_adv;
  logic              w_rr;
  logic              w_sel_b;
  logic              w_sel_we;
  logic [LANES-1:0]  w_sel_be;
  logic [1:0]        w_lane;
  logic [LANES-1:0]  w_be_left;

  assign w_req  = {bus.b_req, bus.a_req};
  assign w_adv  = (r_state == ST_IDLE) && (|w_req);
  assign w_rr   = (RR != 0);

  mem_arb_rr2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req (w_req),
    .i_rr  (w_rr),
    .i_adv (w_adv),
    .o_gnt (w_gnt)
  );

  assign w_sel_b   = w_gnt[1];
  assign w_sel_we  = w_sel_b ? bus.b_we : bus.a_we;
  assign w_sel_be  = w_sel_b ? bus.b_be : bus.a_be;
  assign w_lane    = lowest_lane(r_be);
  assign w_be_left = r_be & ~(4'b0001 << w_lane);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Request fields are captured only at grant; requester inputs are ignored afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt_b <= 1'b0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else if (w_adv) begin
      r_gnt_b <= w_sel_b;
      r_we    <= w_sel_we;
      r_waddr <= w_sel_b ? bus.b_waddr : bus.a_waddr;
      r_wdata <= w_sel_b ? bus.b_wdata : bus.a_wdata;
      r_be    <= w_sel_be;
    end else if (r_state == ST_WR) begin
      r_be    <= w_be_left;
    end
  end

  always_comb begin
    w_next       = r_state;
    bus.mem_we   = 1'b0;
    bus.mem_re   = 1'b0;
    bus.mem_addr = '0;
    bus.mem_wd   = 8'h00;
    bus.a_ack    = 1'b0;
    bus.b_ack    = 1'b0;
    bus.a_rdata  = 32'h0;
    bus.b_rdata  = 32'h0;
    case (r_state)
      ST_IDLE: begin
        if (w_adv) begin
          if (!w_sel_we)            w_next = ST_RD;
          else if (w_sel_be == '0)  w_next = ST_RSP;
          else                      w_next = ST_WR;
        end
      end
      ST_WR: begin
        bus.mem_we   = 1'b1;
        bus.mem_addr = {r_waddr, w_lane};
        bus.mem_wd   = r_wdata[8*w_lane +: 8];
        if (w_be_left == '0) w_next = ST_RSP;
      end
      ST_RD: begin
        bus.mem_re   = 1'b1;
        bus.mem_addr = {r_waddr, 2'b00};
        w_next       = ST_RSP;
      end
      ST_RSP: begin
        if (r_gnt_b) begin
          bus.b_ack   = 1'b1;
          bus.b_rdata = r_we ? 32'h0 : bus.mem_rd;
        end else begin
          bus.a_ack   = 1'b1;
          bus.a_rdata = r_we ? 32'h0 : bus.mem_rd;
        end
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_word_arb.sv
// tb/tb_mem_word_arb.sv - self-checking bench for mem_word_arb
module tb_mem_word_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_word_arb_if #(.ADDR_W(8)) bus0 ();
  mem_word_arb_if #(.ADDR_W(8)) bus1 ();

  mem_word_arb #(.ADDR_W(8), .RR(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  mem_word_arb #(.ADDR_W(8), .RR(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  assign bus1.mem_rd = 32'h0;

  int checks = 0;
  int errors = 0;
  int viol = 0;
  int acks_a = 0;
  int acks_b = 0;
  int exp_acks_a = 0;
  int exp_acks_b = 0;

  logic [7:0]  tb_mem  [256];
  logic [7:0]  ref_mem [256];
  logic [15:0] wlog [$];

  // Byte memory with registered word read; also logs every byte write it sees.
  always @(posedge clk) begin
    if (bus0.mem_we) begin
      tb_mem[bus0.mem_addr] <= bus0.mem_wd;
      wlog.push_back({bus0.mem_addr, bus0.mem_wd});
    end
    if (bus0.mem_re) begin
      bus0.mem_rd <= {tb_mem[{bus0.mem_addr[7:2], 2'd3}], tb_mem[{bus0.mem_addr[7:2], 2'd2}],
                      tb_mem[{bus0.mem_addr[7:2], 2'd1}], tb_mem[{bus0.mem_addr[7:2], 2'd0}]};
    end
    if (bus0.a_ack) acks_a <= acks_a + 1;
    if (bus0.b_ack) acks_b <= acks_b + 1;
    if ((bus0.mem_we && bus0.mem_re) || (bus1.mem_we && bus1.mem_re) ||
        (bus0.a_ack && bus0.b_ack) || (bus1.a_ack && bus1.b_ack)) begin
      viol <= viol + 1;
      $display("protocol violation at %0t", $time);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [5:0] wa);
    return {ref_mem[{wa, 2'd3}], ref_mem[{wa, 2'd2}], ref_mem[{wa, 2'd1}], ref_mem[{wa, 2'd0}]};
  endfunction

  // One transaction on the RR=1 instance; inputs are scrambled after the grant edge.
  task automatic do_txn(input bit is_b, input bit we, input logic [5:0] waddr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output int lat, output logic [31:0] rd);
    bit got;
    got = 0; lat = 0; rd = 32'h0;
    if (is_b) begin
      bus0.b_we = we; bus0.b_waddr = waddr; bus0.b_wdata = wdata; bus0.b_be = be; bus0.b_req = 1'b1;
    end else begin
      bus0.a_we = we; bus0.a_waddr = waddr; bus0.a_wdata = wdata; bus0.a_be = be; bus0.a_req = 1'b1;
    end
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (is_b ? bus0.b_ack : bus0.a_ack) begin
        lat = i; rd = is_b ? bus0.b_rdata : bus0.a_rdata; got = 1;
        break;
      end
      if (i == 1) begin
        if (is_b) begin
          bus0.b_we = ~we; bus0.b_waddr = $urandom; bus0.b_wdata = $urandom; bus0.b_be = $urandom;
        end else begin
          bus0.a_we = ~we; bus0.a_waddr = $urandom; bus0.a_wdata = $urandom; bus0.a_be = $urandom;
        end
      end
    end
    bus0.a_req = 1'b0;
    bus0.b_req = 1'b0;
    check("ack_timeout", got, 1'b1);
    @(posedge clk); #1;
    check("ack_one_cycle", is_b ? bus0.b_ack : bus0.a_ack, 1'b0);
    @(negedge clk);
  endtask

  // Runs a transaction and checks latency, read data and byte-write sequence against the model.
  task automatic run_txn(input string tag, input bit is_b, input bit we, input logic [5:0] waddr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         output int lat, output logic [31:0] rd);
    int exp_lat;
    int idx;
    logic [31:0] exp_rd;
    exp_rd  = we ? 32'h0 : ref_word(waddr);
    exp_lat = !we ? 2 : (be == 4'b0000) ? 1 : $countones(be) + 1;
    wlog.delete();
    do_txn(is_b, we, waddr, wdata, be, lat, rd);
    if (is_b) exp_acks_b++; else exp_acks_a++;
    check({tag, "_latency"}, lat, exp_lat);
    if (!we) check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_nwrites"}, wlog.size(), we ? $countones(be) : 0);
    idx = 0;
    if (we) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) begin
          if (idx < wlog.size())
            check({tag, "_wbyte"}, wlog[idx], {waddr, k[1:0], wdata[8*k +: 8]});
          ref_mem[{waddr, k[1:0]}] = wdata[8*k +: 8];
          idx++;
        end
      end
    end
  endtask

  typedef struct {
    bit          is_b;
    bit          we;
    logic [5:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          exp_lat;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int lat;
    int n;
    int order [4];
    logic [31:0] rd;
    bit got;

    for (int i = 0; i < 256; i++) begin tb_mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    bus0.a_req = 0; bus0.a_we = 0; bus0.a_waddr = 0; bus0.a_wdata = 0; bus0.a_be = 0;
    bus0.b_req = 0; bus0.b_we = 0; bus0.b_waddr = 0; bus0.b_wdata = 0; bus0.b_be = 0;
    bus1.a_req = 0; bus1.a_we = 0; bus1.a_waddr = 0; bus1.a_wdata = 0; bus1.a_be = 0;
    bus1.b_req = 0; bus1.b_we = 0; bus1.b_waddr = 0; bus1.b_wdata = 0; bus1.b_be = 0;

    vecs[0] = '{0, 1, 6'h05, 32'hDDCCBBAA, 4'b1111, 5, 32'h0};
    vecs[1] = '{0, 0, 6'h05, 32'h0,        4'b0000, 2, 32'hDDCCBBAA};
    vecs[2] = '{1, 1, 6'h3F, 32'h11223344, 4'b1010, 3, 32'h0};
    vecs[3] = '{1, 0, 6'h3F, 32'h0,        4'b1111, 2, 32'h11003300};
    vecs[4] = '{0, 1, 6'h10, 32'hCAFEF00D, 4'b0000, 1, 32'h0};
    vecs[5] = '{0, 0, 6'h10, 32'h0,        4'b0000, 2, 32'h0};
    vecs[6] = '{1, 1, 6'h00, 32'hA1B2C3D4, 4'b1000, 2, 32'h0};
    vecs[7] = '{0, 0, 6'h00, 32'h0,        4'b0000, 2, 32'hA1000000};

    repeat (3) @(negedge clk);
    check("rst_mem_we", bus0.mem_we, 1'b0);
    check("rst_mem_re", bus0.mem_re, 1'b0);
    check("rst_mem_addr", bus0.mem_addr, 8'h00);
    check("rst_mem_wd", bus0.mem_wd, 8'h00);
    check("rst_acks", {bus0.a_ack, bus0.b_ack}, 2'b00);
    rst_n = 1'b1;
    @(negedge clk);

    // Round-robin tie: both requesters hold reads, expect A,B,A,B.
    bus0.a_we = 0; bus0.a_waddr = 6'h05; bus0.b_we = 0; bus0.b_waddr = 6'h3F;
    bus0.a_req = 1; bus0.b_req = 1;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(posedge clk); #1;
      if (bus0.a_ack) begin order[n] = 0; n++; check("rr_rdata_a", bus0.a_rdata, ref_word(6'h05)); end
      else if (bus0.b_ack) begin order[n] = 1; n++; check("rr_rdata_b", bus0.b_rdata, ref_word(6'h3F)); end
    end
    bus0.a_req = 0; bus0.b_req = 0;
    check("rr_count", n, 4);
    check("rr_order", {order[0][0], order[1][0], order[2][0], order[3][0]}, 4'b0101);
    exp_acks_a += 2; exp_acks_b += 2;
    @(posedge clk); @(negedge clk);

    // Fixed priority: A wins every tie until it drops, then B is served.
    bus1.a_req = 1; bus1.b_req = 1;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(posedge clk); #1;
      if (bus1.a_ack) begin order[n] = 0; n++; end
      else if (bus1.b_ack) begin order[n] = 1; n++; end
      if (n == 3) bus1.a_req = 0;
      if (n == 4) bus1.b_req = 0;
    end
    bus1.a_req = 0; bus1.b_req = 0;
    check("fp_count", n, 4);
    check("fp_order", {order[0][0], order[1][0], order[2][0], order[3][0]}, 4'b0001);
    @(posedge clk); @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      run_txn($sformatf("vec%0d", v), vecs[v].is_b, vecs[v].we, vecs[v].waddr,
              vecs[v].wdata, vecs[v].be, lat, rd);
      check($sformatf("vec%0d_tbl_lat", v), lat, vecs[v].exp_lat);
      if (!vecs[v].we) check($sformatf("vec%0d_tbl_rd", v), rd, vecs[v].exp_rd);
    end
    check("untouched_fc", tb_mem[8'hFC], 8'h00);
    check("untouched_fe", tb_mem[8'hFE], 8'h00);

    // Reset during the second byte of a full-word write.
    bus0.a_we = 1; bus0.a_waddr = 6'h20; bus0.a_wdata = 32'h44332211; bus0.a_be = 4'b1111;
    bus0.a_req = 1;
    @(posedge clk); #1;
    check("mid_byte0_addr", {bus0.mem_we, bus0.mem_addr}, {1'b1, 8'h80});
    @(posedge clk); #1;
    check("mid_byte1_addr", {bus0.mem_we, bus0.mem_addr}, {1'b1, 8'h81});
    rst_n = 1'b0; #1;
    check("mid_rst_we", bus0.mem_we, 1'b0);
    check("mid_rst_ack", bus0.a_ack, 1'b0);
    @(negedge clk); @(posedge clk); @(negedge clk);
    check("mid_byte0_written", tb_mem[8'h80], 8'h11);
    check("mid_byte1_kept", {tb_mem[8'h81], tb_mem[8'h82], tb_mem[8'h83]}, 24'h0);
    rst_n = 1'b1;
    got = 0; lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus0.a_ack) begin lat = i; got = 1; break; end
    end
    bus0.a_req = 0;
    check("mid_regrant_ack", got, 1'b1);
    check("mid_regrant_lat", lat, 5);
    exp_acks_a++;
    for (int k = 0; k < 4; k++) ref_mem[8'h80 + k] = 8'h11 * (k + 1);
    @(posedge clk); @(negedge clk);
    check("mid_rewrite", {tb_mem[8'h83], tb_mem[8'h82], tb_mem[8'h81], tb_mem[8'h80]}, 32'h44332211);

    for (int t = 0; t < 150; t++) begin
      run_txn("rnd", 1'($urandom), 1'($urandom), 6'($urandom_range(0, 7)),
              $urandom, 4'($urandom), lat, rd);
    end

    repeat (3) @(negedge clk);
    check("ack_count_a", acks_a, exp_acks_a);
    check("ack_count_b", acks_b, exp_acks_b);
    check("protocol_violations", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
